seq_divider: RTL and testbench



---
 rtl/seq_divider_pkg.sv | 12 +
 rtl/seq_divider_div_step.sv | 23 ++
 rtl/seq_divider.sv | 136 +++++++++++++
 tb/tb_seq_divider.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential restoring divider: FSM encoding and default width.
package seq_divider_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_divider_div_step.sv
// One combinational restoring-division step, built on the a + ~b + 1 subtract
// structure: try Pshift - D, keep the difference unless it borrowed.
module div_step #(
  parameter int WIDTH = seq_divider_pkg::DEFAULT_WIDTH
) (
  input  logic [WIDTH:0]   p_shift,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] p_next,
  output logic             q_bit,
  output logic             borrow
);

  logic [WIDTH:0] diff;

  always_comb begin
    diff   = p_shift + ~{1'b0, d} + {{WIDTH{1'b0}}, 1'b1};
    borrow = diff[WIDTH];
    q_bit  = ~borrow;
    // The partial remainder always stays below D, so its top bit is always zero.
    p_next = borrow ? p_shift[WIDTH-1:0] : diff[WIDTH-1:0];
  end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock, one
// operation in flight, divide-by-zero short-circuits straight to DONE.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] p_reg, p_next;
  logic [WIDTH-1:0] q_reg, q_next;
  logic [WIDTH-1:0] d_reg, d_next;
  logic [CW-1:0]    count_reg, count_next;
  logic             busy_reg, busy_next;
  logic             done_reg, done_next;
  logic [WIDTH-1:0] quotient_reg, quotient_next;
  logic [WIDTH-1:0] remainder_reg, remainder_next;
  logic             dbz_reg, dbz_next;

  logic [WIDTH:0]   p_shift;
  logic [WIDTH-1:0] step_p;
  logic             step_q_bit;
  logic             step_borrow;

  assign p_shift = {p_reg, q_reg[WIDTH-1]};

  div_step #(.WIDTH(WIDTH)) u_step (
    .p_shift (p_shift),
    .d       (d_reg),
    .p_next  (step_p),
    .q_bit   (step_q_bit),
    .borrow  (step_borrow)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      p_reg         <= '0;
      q_reg         <= '0;
      d_reg         <= '0;
      count_reg     <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      quotient_reg  <= '0;
      remainder_reg <= '0;
      dbz_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      p_reg         <= p_next;
      q_reg         <= q_next;
      d_reg         <= d_next;
      count_reg     <= count_next;
      busy_reg      <= busy_next;
      done_reg      <= done_next;
      quotient_reg  <= quotient_next;
      remainder_reg <= remainder_next;
      dbz_reg       <= dbz_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    p_next         = p_reg;
    q_next         = q_reg;
    d_next         = d_reg;
    count_next     = count_reg;
    busy_next      = busy_reg;
    done_next      = 1'b0;
    quotient_next  = quotient_reg;
    remainder_next = remainder_reg;
    dbz_next       = dbz_reg;

    assert (step_q_bit != step_borrow);

    case (state_reg)
      IDLE, DONE: begin
        busy_next  = 1'b0;
        state_next = IDLE;
        if (start) begin
          p_next     = '0;
          q_next     = dividend;
          d_next     = divisor;
          count_next = '0;
          if (divisor != '0) begin
            state_next = RUN;
            busy_next  = 1'b1;
          end else begin
            state_next     = DONE;
            quotient_next  = '1;
            remainder_next = dividend;
            dbz_next       = 1'b1;
            done_next      = 1'b1;
          end
        end
      end
      RUN: begin
        // start is deliberately ignored here; the captured operands stay put.
        p_next     = step_p;
        q_next     = {q_reg[WIDTH-2:0], step_q_bit};
        count_next = count_reg + CW'(1);
        if (count_reg == CW'(WIDTH - 1)) begin
          state_next     = DONE;
          quotient_next  = {q_reg[WIDTH-2:0], step_q_bit};
          remainder_next = step_p;
          dbz_next       = 1'b0;
          done_next      = 1'b1;
          busy_next      = 1'b0;
        end
      end
      default: begin
        state_next = IDLE;
        busy_next  = 1'b0;
      end
    endcase
  end

  assign busy        = busy_reg;
  assign done        = done_reg;
  assign quotient    = quotient_reg;
  assign remainder   = remainder_reg;
  assign div_by_zero = dbz_reg;

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider (WIDTH=8): latency, boundaries, divide by zero,
// start during RUN, asynchronous reset mid-operation, back-to-back, random invariant sweep.
module tb_seq_divider;

  localparam int W = 8;

  bit           clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; issues one start, waits (bounded) for done, checks results.
  // inject_at >= 0 pulses a second start with 50/5 that many cycles into RUN.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] exp_q, input logic [W-1:0] exp_r,
                        input logic exp_dbz, input int exp_lat, input int inject_at);
    int n;
    int busy_cnt;
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(negedge clk);
    start    = 1'b0;
    dividend = 8'hXX;
    divisor  = 8'hXX;
    n        = 0;
    busy_cnt = 0;
    while (!done && n < 20) begin
      if (busy) busy_cnt++;
      if (n == inject_at) begin
        start    = 1'b1;
        dividend = 8'd50;
        divisor  = 8'd5;
      end
      @(negedge clk);
      start = 1'b0;
      n++;
    end
    $display("op %0d/%0d -> q=%0d r=%0d dbz=%0b latency=%0d", a, b, quotient, remainder, div_by_zero, n);
    check("latency", n, exp_lat);
    check("busy_cycles", busy_cnt, exp_lat);
    check("quotient", quotient, exp_q);
    check("remainder", remainder, exp_r);
    check("div_by_zero", div_by_zero, exp_dbz);
  endtask

  task automatic expect_done_low();
    @(negedge clk);
    check("done_one_cycle", done, 1'b0);
  endtask

  initial begin
    int dones;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [15:0] recon;

    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    @(negedge clk);
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_quotient", quotient, 8'd0);
    check("reset_remainder", remainder, 8'd0);
    check("reset_dbz", div_by_zero, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 8, -1);
    expect_done_low();
    run_op(8'd255, 8'd1, 8'd255, 8'd0, 1'b0, 8, -1);
    expect_done_low();
    run_op(8'd5, 8'd9, 8'd0, 8'd5, 1'b0, 8, -1);
    expect_done_low();
    run_op(8'd0, 8'd3, 8'd0, 8'd0, 1'b0, 8, -1);
    expect_done_low();
    run_op(8'd255, 8'd255, 8'd1, 8'd0, 1'b0, 8, -1);
    expect_done_low();

    // Divide by zero: done right after the start edge, no RUN cycles.
    run_op(8'd200, 8'd0, 8'hFF, 8'hC8, 1'b1, 0, -1);
    expect_done_low();
    check("dbz_holds", div_by_zero, 1'b1);

    // A start during RUN must be ignored and produce no second done.
    run_op(8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 8, 3);
    dones = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("no_second_done", dones, 0);

    // Asynchronous reset in the middle of an operation.
    start    = 1'b1;
    dividend = 8'd100;
    divisor  = 8'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_busy", busy, 1'b0);
    check("async_rst_done", done, 1'b0);
    check("async_rst_quotient", quotient, 8'd0);
    check("async_rst_remainder", remainder, 8'd0);
    check("async_rst_dbz", div_by_zero, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    repeat (12) begin
      @(negedge clk);
      if (done || busy) dones++;
    end
    check("abandoned_op_silent", dones, 0);
    run_op(8'd60, 8'd8, 8'd7, 8'd4, 1'b0, 8, -1);
    expect_done_low();

    // Back-to-back: the second start lands in the DONE cycle of the first.
    run_op(8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 8, -1);
    run_op(8'd17, 8'd4, 8'd4, 8'd1, 1'b0, 8, -1);
    expect_done_low();

    // Random sweep against the division invariant.
    for (int i = 0; i < 1000; i++) begin
      a = W'($urandom_range(255, 0));
      b = W'($urandom_range(255, 1));
      run_op(a, b, a / b, a % b, 1'b0, 8, -1);
      recon = 16'(quotient) * 16'(b) + 16'(remainder);
      check("invariant_recon", recon, 16'(a));
      check("invariant_r_lt_d", (remainder < b) ? 1 : 0, 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
